lsu_mem_ctrl: RTL
=================

Name: lsu_mem_ctrl

Overview:
Load/store sequencing stage between the core's execute result and data memory.
- Checks alignment, builds byte enables and lane-shifted store data, and runs a valid/ready request to data memory.
- For loads, captures the returned word and right-justifies it into bits [7:0]/[15:0], so the load-extension stage (lb/lh/lbu/lhu/lw sign/zero extension) consumes it directly as memdataOut.
- Stalls the single-cycle core until each access completes.

Parameters:
- ADDR_W, 32, byte-address width on both sides.
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT before abort; 0 disables the timeout.
- TO_W, $clog2(TIMEOUT+1), width of the timeout counter (derived, not overridden).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- core_req  in  1  memory instruction present; held high until core_done.
- core_store  in  1  1=store (opcode 0100011), 0=load (0000011); sampled with core_req.
- core_funct3  in  3  instruction[14:12].
- core_addr  in  ADDR_W  effective byte address.
- core_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- core_stall  out  1  freeze PC/regfile write.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  misaligned, illegal funct3, or timeout; valid with core_done.
- load_data  out  32  right-justified load word, feeds the extension stage.
- m_valid  out  1  memory request valid.
- m_ready  in  1  memory accepts the request.
- m_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00}).
- m_we  out  1  write enable.
- m_be  out  4  byte enables.
- m_wdata  out  32  lane-aligned store data.
- m_rvalid  in  1  read data valid.
- m_rdata  in  32  read word.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0, load_data=0, timeout counter=0. Any in-flight request is dropped immediately and m_valid falls asynchronously.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, core_req=1:
  - Decode funct3. Loads: 000/100 byte, 001/101 half, 010 word, others illegal. Stores: 000/001/010 legal, others illegal.
  - Misaligned means half with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned: no memory access; latch err=1; go to DONE.
  - Otherwise latch addr, off=addr[1:0], store flag, funct3, wdata; go to REQ.
- REQ:
  - m_valid=1; m_addr/m_we/m_be/m_wdata are registered and must stay stable until m_valid&&m_ready.
  - On handshake: a store goes to DONE; a load goes to WAIT.
- WAIT: on m_rvalid, load_data <= m_rdata >> (8*off); go to DONE. m_rvalid is ignored in every other state.
- Timeout:
  - Counter clears on entry to REQ and increments each cycle in REQ/WAIT.
  - When TIMEOUT!=0 and the counter reaches TIMEOUT-1 without progress: drop m_valid, set err=1, go to DONE; load_data is unchanged.
- DONE: core_done=1 and core_err=err for exactly one cycle; then go to IDLE and clear err.
- core_stall = core_req && !core_done (combinational).
  - A legal access stalls the core at least 2 cycles (IDLE, REQ) before the DONE cycle.
  - An error access stalls 1 cycle.
- Byte enables:
  - byte: 4'b0001<<off.
  - half: 4'b0011<<off.
  - word: 4'b1111.
  - loads also drive the enables; m_we=0 for loads.
- Store data: m_wdata = core_wdata << (8*off), with unused lanes 0.
- load_data holds its value until the next successful load. It is never modified by stores, errors, or timeouts.
- A new core_req is accepted only in IDLE. core_req falling mid-access does not abort the access; it completes and core_done still pulses.
- m_ready asserted while m_valid=0 has no effect.

Decomposition:
- Shared package lsu_pkg:
  - state enum.
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011.
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - function size_of(funct3) returning 0/1/2.
- One natural sub-module: lsu_align, purely combinational. Inputs funct3, off, store; outputs legal, misaligned, be, wdata shift, and rdata shift.

Test Plan:
- sw addr=0x104, wdata=0xDEADBEEF, m_ready on the first REQ cycle -> m_be=1111, m_addr=0x104, m_wdata=0xDEADBEEF; core_done on cycle 3; core_err=0.
- sb addr=0x103, wdata=0x000000A5 -> m_be=1000, m_wdata=0xA5000000, m_we=1.
- lh addr=0x202, m_rdata=0x8001_1234, m_rvalid 2 cycles after the handshake -> load_data=0x00008001; core_done the cycle after m_rvalid.
- lw addr=0x301 -> no m_valid; core_done=core_err=1 the cycle after core_req; stall lasts 1 cycle; load_data unchanged.
- lbu addr=0x400, m_ready held 0, TIMEOUT=16 -> m_valid high 16 cycles then drops; core_err=1; load_data unchanged.
- Load in WAIT, rst_n pulsed low -> m_valid=0 and core_stall=0 immediately; the next lw addr=0x0 completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : lsu_pkg
// Brief   : Shared types, opcode/funct3 constants and size decode for the LSU.
// Revision: 1.0 - initial release
// ============================================================================
package lsu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // 0 = byte, 1 = half, 2 = word; illegal encodings are caught separately
  function automatic logic [1:0] size_of(input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_BU: size_of = 2'd0;
      F3_H, F3_HU: size_of = 2'd1;
      default:     size_of = 2'd2;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Access legality, alignment, byte enables and lane shifting.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic        store,
  input  logic [31:0] wdata_in,
  input  logic [31:0] rdata_in,
  output logic        legal,
  output logic        misaligned,
  output logic [3:0]  be,
  output logic [31:0] wdata_out,
  output logic [31:0] rdata_out
);

  logic [1:0]  w_size;
  logic [31:0] w_wmask;

  assign w_size = size_of(funct3);

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    be         = 4'b1111;
    w_wmask    = 32'hFFFF_FFFF;
    case (funct3)
      F3_B, F3_H, F3_W: legal = 1'b1;
      F3_BU, F3_HU:     legal = !store;
      default:          legal = 1'b0;
    endcase
    case (w_size)
      2'd0: begin
        be      = 4'b0001 << off;
        w_wmask = 32'h0000_00FF;
      end
      2'd1: begin
        be         = 4'b0011 << off;
        w_wmask    = 32'h0000_FFFF;
        misaligned = off[0];
      end
      default: begin
        be         = 4'b1111;
        misaligned = (off != 2'b00);
      end
    endcase
  end

  // Unused lanes are zeroed before shifting so stray upper bits never leak
  assign wdata_out = store ? ((wdata_in & w_wmask) << {off, 3'b000}) : 32'h0;
  assign rdata_out = rdata_in >> {off, 3'b000};

endmodule
`default_nettype wire

// File: rtl/lsu_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : lsu_mem_ctrl
// Brief   : Load/store sequencer between execute stage and data memory.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_mem_ctrl
  import lsu_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int TO_W    = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              core_req,
  input  logic              core_store,
  input  logic [2:0]        core_funct3,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [31:0]       core_wdata,
  output logic              core_stall,
  output logic              core_done,
  output logic              core_err,
  output logic [31:0]       load_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ADDR_W-1:0] m_addr,
  output logic              m_we,
  output logic [3:0]        m_be,
  output logic [31:0]       m_wdata,
  input  logic              m_rvalid,
  input  logic [31:0]       m_rdata
);

  localparam int             CNT_W    = (TO_W > 0) ? TO_W : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic           C_TO_EN  = (TIMEOUT != 0);

  lsu_state_t        r_state, w_next;
  logic              r_err;
  logic [CNT_W-1:0]  r_cnt;
  logic [ADDR_W-3:0] r_waddr;
  logic [1:0]        r_off;
  logic              r_store;
  logic [3:0]        r_be;
  logic [31:0]       r_wdata;
  logic [31:0]       r_load;

  logic [1:0]        w_off;
  logic              w_legal, w_misal, w_bad;
  logic [3:0]        w_be;
  logic [31:0]       w_wdata, w_rdata;
  logic              w_progress, w_timeout;

  // Decode uses the live address in IDLE; the read shift needs the latched offset
  assign w_off = (r_state == S_IDLE) ? core_addr[1:0] : r_off;

  lsu_align u_align (
    .funct3     (core_funct3),
    .off        (w_off),
    .store      (core_store),
    .wdata_in   (core_wdata),
    .rdata_in   (m_rdata),
    .legal      (w_legal),
    .misaligned (w_misal),
    .be         (w_be),
    .wdata_out  (w_wdata),
    .rdata_out  (w_rdata)
  );

  assign w_bad      = !w_legal || w_misal;
  assign w_progress = ((r_state == S_REQ) && m_ready) || ((r_state == S_WAIT) && m_rvalid);
  assign w_timeout  = C_TO_EN && ((r_state == S_REQ) || (r_state == S_WAIT)) &&
                      (r_cnt == CNT_LAST) && !w_progress;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (core_req) w_next = w_bad ? S_DONE : S_REQ;
      S_REQ: begin
        if (m_ready)        w_next = r_store ? S_DONE : S_WAIT;
        else if (w_timeout) w_next = S_DONE;
      end
      S_WAIT: if (m_rvalid || w_timeout) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_off   <= 2'b00;
      r_store <= 1'b0;
      r_be    <= 4'b0000;
      r_wdata <= 32'h0;
      r_load  <= 32'h0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (core_req) begin
            r_err <= w_bad;
            if (!w_bad) begin
              r_waddr <= core_addr[ADDR_W-1:2];
              r_off   <= core_addr[1:0];
              r_store <= core_store;
              r_be    <= w_be;
              r_wdata <= w_wdata;
              r_cnt   <= '0;
            end
          end
        end
        S_REQ, S_WAIT: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout) r_err <= 1'b1;
          if ((r_state == S_WAIT) && m_rvalid) r_load <= w_rdata;
        end
        S_DONE:  r_err <= 1'b0;
        default: ;
      endcase
    end
  end

  assign m_valid   = (r_state == S_REQ);
  assign m_addr    = {r_waddr, 2'b00};
  assign m_we      = r_store;
  assign m_be      = r_be;
  assign m_wdata   = r_wdata;
  assign load_data = r_load;
  assign core_done = (r_state == S_DONE);
  assign core_err  = core_done && r_err;
  // Gated by rst_n so the core is released the instant reset asserts
  assign core_stall = rst_n && core_req && !core_done;

endmodule
`default_nettype wire
